// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate convolution unit: accumulates KERNEL_N signal*weight
// products, adds a scaled bias, optionally rounds, shifts and saturates to OUT_W.
`timescale 1ns/1ps
module conv_mac_unit #(
    parameter int DATA_W     = 8,
    parameter int WEIGHT_W   = 8,
    parameter int BIAS_W     = 8,
    parameter int KERNEL_N   = 9,
    parameter int ACC_W      = 24,
    parameter int BIAS_SHIFT = 6,
    parameter int SHIFT      = 9,
    parameter int OUT_W      = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                sat_en,
    input  logic                round_en,
    input  logic [BIAS_W-1:0]   bias,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_signal,
    input  logic [WEIGHT_W-1:0] in_weight,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_sat
);

    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int CNT_W  = $clog2(KERNEL_N + 1);
    localparam int W_A    = (ACC_W > BIAS_W + BIAS_SHIFT) ? ACC_W : BIAS_W + BIAS_SHIFT;
    localparam int W_B    = (W_A > SHIFT + 1) ? W_A : SHIFT + 1;
    // Two spare bits keep the bias/round additions from overflowing the final sum.
    localparam int SUM_W  = ((W_B > OUT_W) ? W_B : OUT_W) + 2;

    localparam logic signed [SUM_W-1:0] OUT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] OUT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;
    localparam logic [1:0] OUT    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  tap_cnt_q, tap_cnt_d;
    logic [BIAS_W-1:0] bias_q, bias_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_sat_q, out_sat_d;

    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]         prod_ext;
    logic [SUM_W-1:0]         acc_ext, bias_sh, rnd, sum;
    logic signed [SUM_W-1:0]  res;
    logic [OUT_W-1:0]         res_data;
    logic                     res_sat;
    logic                     tap_xfer;

    assign in_ready  = ((state_q == IDLE) || (state_q == ACCUM)) && !clear;
    assign tap_xfer  = in_valid && in_ready;
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        prod     = $signed(in_signal) * $signed(in_weight);
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        acc_ext  = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        bias_sh  = {{(SUM_W-BIAS_W){bias_q[BIAS_W-1]}}, bias_q} << BIAS_SHIFT;
        rnd      = round_en ? ({{(SUM_W-1){1'b0}}, 1'b1} << (SHIFT - 1)) : '0;
        sum      = acc_ext + bias_sh + rnd;
        res      = $signed(sum) >>> SHIFT;
    end

    always_comb begin
        res_data = res[OUT_W-1:0];
        res_sat  = 1'b0;
        if (sat_en) begin
            if (res > OUT_MAX) begin
                res_data = OUT_MAX[OUT_W-1:0];
                res_sat  = 1'b1;
            end else if (res < OUT_MIN) begin
                res_data = OUT_MIN[OUT_W-1:0];
                res_sat  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        tap_cnt_d  = tap_cnt_q;
        bias_d     = bias_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (clear) begin
            state_d   = IDLE;
            acc_d     = '0;
            tap_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tap_xfer) begin
                        acc_d     = prod_ext;
                        bias_d    = bias;
                        tap_cnt_d = CNT_W'(1);
                        state_d   = (KERNEL_N == 1) ? FINISH : ACCUM;
                    end
                end
                ACCUM: begin
                    if (tap_xfer) begin
                        acc_d     = acc_q + prod_ext;
                        tap_cnt_d = tap_cnt_q + CNT_W'(1);
                        if (tap_cnt_q == CNT_W'(KERNEL_N - 1)) begin
                            state_d = FINISH;
                        end
                    end
                end
                FINISH: begin
                    out_data_d = res_data;
                    out_sat_d  = res_sat;
                    tap_cnt_d  = '0;
                    state_d    = OUT;
                end
                default: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            tap_cnt_q  <= '0;
            bias_q     <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            tap_cnt_q  <= tap_cnt_d;
            bias_q     <= bias_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_conv_mac_unit.sv
// Directed bench for conv_mac_unit with hand-computed expected results.
`timescale 1ns/1ps
module tb_conv_mac_unit;

    logic       clk = 1'b0;
    logic       reset_n, clear, sat_en, round_en;
    logic [7:0] bias, in_signal, in_weight, out_data;
    logic       in_valid, in_ready, out_valid, out_ready, out_sat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_mac_unit #(
        .DATA_W(8), .WEIGHT_W(8), .BIAS_W(8), .KERNEL_N(9),
        .ACC_W(24), .BIAS_SHIFT(6), .SHIFT(9), .OUT_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .sat_en(sat_en),
        .round_en(round_en), .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
        .in_signal(in_signal), .in_weight(in_weight), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n, input int s, input int w, input int b);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b1;
            in_signal = s[7:0];
            in_weight = w[7:0];
            bias      = b[7:0];
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Nine taps, then FINISH (no valid yet), then OUT with the result; out_ready=1.
    task automatic pixel(input string tag, input int s, input int w, input int b,
                         input int exp_d, input int exp_s);
        feed(9, s, w, b);
        chk({tag, "_fin_valid"}, int'(out_valid), 0);
        chk({tag, "_fin_ready"}, int'(in_ready), 0);
        tick();
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_data"}, int'($signed(out_data)), exp_d);
        chk({tag, "_sat"}, int'(out_sat), exp_s);
        tick();
        chk({tag, "_idle"}, int'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; clear = 1'b0; sat_en = 1'b1; round_en = 1'b0;
        bias = '0; in_valid = 1'b0; in_signal = '0; in_weight = '0; out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'($signed(out_data)), 0);
        chk("rst_sat", int'(out_sat), 0);
        reset_n = 1'b1;
        tick();
        chk("rst_ready", int'(in_ready), 1);

        pixel("t1", 10, 20, 2, 3, 0);
        round_en = 1'b1;
        pixel("t2", 10, 20, 2, 4, 0);
        round_en = 1'b0;
        pixel("t3_sat", 127, 127, 0, 127, 1);
        sat_en = 1'b0;
        pixel("t3_wrap", 127, 127, 0, 27, 0);
        pixel("t4_wrap", -128, 127, 0, -30, 0);
        sat_en = 1'b1;
        pixel("t4_sat", -128, 127, 0, -128, 1);

        out_ready = 1'b0;
        feed(9, 10, 20, 2);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_ready", int'(in_ready), 0);
            chk("t5_hold_valid", int'(out_valid), 1);
            chk("t5_hold_data", int'($signed(out_data)), 3);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("t5_release_valid", int'(out_valid), 0);
        chk("t5_release_ready", int'(in_ready), 1);
        pixel("t5_next", 10, 20, 2, 3, 0);

        feed(4, 50, 50, 100);
        clear = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("t6_clear_ready", int'(in_ready), 0);
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("t6_clear_valid", int'(out_valid), 0);
        pixel("t6_after_clear", 10, 20, 2, 3, 0);

        feed(3, 100, 100, 50);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_arst_data", int'($signed(out_data)), 0);
        chk("t6_arst_valid", int'(out_valid), 0);
        chk("t6_arst_sat", int'(out_sat), 0);
        #2;
        reset_n = 1'b1;
        tick();
        pixel("t6_after_rst", 10, 20, 2, 3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
